// File: rtl/enc_quad_gen_if.sv
// enc_quad_gen_if
//   Command channel of the quadrature generator. A command moves on a clock
//   edge where cmd_valid and cmd_ready are both high.
//
//   cmd_valid   master -> slave  command offered
//   cmd_ready   slave -> master  generator can take a command
//   cmd_period  master -> slave  quarter-cycle period in clk ticks
//   cmd_dir     master -> slave  1 = A leads B (count up), 0 = B leads A
//   cmd_edges   master -> slave  quarter-cycle edges to emit, 0 = continuous
interface enc_quad_gen_if #(
  parameter int WIDTH     = 26,
  parameter int CNT_WIDTH = 16
) ();
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [WIDTH-1:0]     cmd_period;
  logic                 cmd_dir;
  logic [CNT_WIDTH-1:0] cmd_edges;

  modport master (
    output cmd_valid,
    output cmd_period,
    output cmd_dir,
    output cmd_edges,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_period,
    input  cmd_dir,
    input  cmd_edges,
    output cmd_ready
  );
endinterface

// File: rtl/enc_quad_gen.sv
// enc_quad_gen
//   Quadrature encoder signal generator. Emits A/B waveforms with a
//   programmed quarter-cycle period, direction and edge count, and keeps a
//   signed position count of the edges it has produced. One command can be
//   buffered while another runs, so back-to-back moves join seamlessly.
//
//   clk    in   system clock
//   reset  in   asynchronous, active-low
//   cmd    if   command channel (slave modport)
//   stop   in   synchronous abort; clears the buffered command
//   a, b   out  encoder channels
//   dir    out  direction of the active command
//   busy   out  high while running
//   done   out  one-cycle pulse when a finite move finishes with nothing queued
//   pos    out  signed position, +1 per edge up, -1 per edge down, wraps
module enc_quad_gen #(
  parameter int WIDTH     = 26,
  parameter int CNT_WIDTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  enc_quad_gen_if.slave       cmd,
  input  logic                stop,
  output logic                a,
  output logic                b,
  output logic                dir,
  output logic                busy,
  output logic                done,
  output logic [31:0]         pos
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     period_q, period_d;
  logic                 dir_q, dir_d;
  logic [CNT_WIDTH-1:0] remaining_q, remaining_d;
  logic [WIDTH-1:0]     timer_q, timer_d;
  logic [1:0]           phase_q, phase_d;
  logic [31:0]          pos_q, pos_d;
  logic                 done_q, done_d;
  logic                 pend_valid_q, pend_valid_d;
  logic [WIDTH-1:0]     pend_period_q, pend_period_d;
  logic                 pend_dir_q, pend_dir_d;
  logic [CNT_WIDTH-1:0] pend_edges_q, pend_edges_d;

  logic                 accept;
  logic [WIDTH-1:0]     new_period;
  logic                 src_valid;
  logic [WIDTH-1:0]     src_period;
  logic                 src_dir;
  logic [CNT_WIDTH-1:0] src_edges;
  logic                 expire;
  logic                 finite;
  logic                 last_edge;

  assign cmd.cmd_ready = !pend_valid_q && !stop;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

  // Periods below 2 would need an edge every cycle or none at all.
  assign new_period = (cmd.cmd_period < WIDTH'(2)) ? WIDTH'(2) : cmd.cmd_period;

  // Next command to run at an edge: the buffered one, or one arriving on
  // this very edge (the slot is then empty, so it still joins seamlessly).
  assign src_valid  = pend_valid_q || accept;
  assign src_period = pend_valid_q ? pend_period_q : new_period;
  assign src_dir    = pend_valid_q ? pend_dir_q    : cmd.cmd_dir;
  assign src_edges  = pend_valid_q ? pend_edges_q  : cmd.cmd_edges;

  assign expire    = (timer_q == WIDTH'(1));
  assign finite    = (remaining_q != '0);
  assign last_edge = (remaining_q == CNT_WIDTH'(1));

  always_comb begin
    state_d       = state_q;
    period_d      = period_q;
    dir_d         = dir_q;
    remaining_d   = remaining_q;
    timer_d       = timer_q;
    phase_d       = phase_q;
    pos_d         = pos_q;
    done_d        = 1'b0;
    pend_valid_d  = pend_valid_q;
    pend_period_d = pend_period_q;
    pend_dir_d    = pend_dir_q;
    pend_edges_d  = pend_edges_q;

    unique case (state_q)
      IDLE: begin
        // From idle the command bypasses the buffer and starts at once.
        if (accept) begin
          state_d     = RUN;
          period_d    = new_period;
          dir_d       = cmd.cmd_dir;
          remaining_d = cmd.cmd_edges;
          timer_d     = new_period;
        end
      end
      RUN: begin
        if (stop) begin
          // Abort takes priority over any edge due this cycle.
          state_d      = IDLE;
          pend_valid_d = 1'b0;
        end else begin
          if (accept) begin
            pend_valid_d  = 1'b1;
            pend_period_d = new_period;
            pend_dir_d    = cmd.cmd_dir;
            pend_edges_d  = cmd.cmd_edges;
          end
          if (!expire) begin
            timer_d = timer_q - WIDTH'(1);
          end else begin
            // Edge emitted in the current direction; phase continues across
            // a swap so a reversal neither skips nor repeats a state.
            phase_d = dir_q ? phase_q + 2'd1 : phase_q - 2'd1;
            pos_d   = dir_q ? pos_q + 32'd1  : pos_q - 32'd1;
            if (src_valid && (!finite || last_edge)) begin
              period_d     = src_period;
              dir_d        = src_dir;
              remaining_d  = src_edges;
              timer_d      = src_period;
              pend_valid_d = 1'b0;
            end else if (finite && last_edge) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              timer_d = period_q;
              if (finite) begin
                remaining_d = remaining_q - CNT_WIDTH'(1);
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      period_q      <= '0;
      dir_q         <= 1'b0;
      remaining_q   <= '0;
      timer_q       <= '0;
      phase_q       <= 2'd0;
      pos_q         <= 32'd0;
      done_q        <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_period_q <= '0;
      pend_dir_q    <= 1'b0;
      pend_edges_q  <= '0;
    end else begin
      state_q       <= state_d;
      period_q      <= period_d;
      dir_q         <= dir_d;
      remaining_q   <= remaining_d;
      timer_q       <= timer_d;
      phase_q       <= phase_d;
      pos_q         <= pos_d;
      done_q        <= done_d;
      pend_valid_q  <= pend_valid_d;
      pend_period_q <= pend_period_d;
      pend_dir_q    <= pend_dir_d;
      pend_edges_q  <= pend_edges_d;
    end
  end

  // Phase map 0->00, 1->10, 2->11, 3->01 (a,b) is a Gray sequence.
  assign a    = phase_q[1] ^ phase_q[0];
  assign b    = phase_q[1];
  assign dir  = dir_q;
  assign busy = (state_q == RUN);
  assign done = done_q;
  assign pos  = pos_q;

endmodule

// File: tb/tb_enc_quad_gen.sv
// tb_enc_quad_gen
//   Self-checking bench for enc_quad_gen. Finite moves come from a vector
//   table; swaps, stop and async reset are hand-written sequences. Every
//   expected edge (a, b, pos, cycle, done) is queued when its command is
//   driven and compared when the generator toggles a channel.
module tb_enc_quad_gen;

  logic        clk;
  logic        reset;
  logic        stop;
  logic        a;
  logic        b;
  logic        dir;
  logic        busy;
  logic        done;
  logic [31:0] pos;

  enc_quad_gen_if #(.WIDTH(26), .CNT_WIDTH(16)) cmd_if ();

  enc_quad_gen #(.WIDTH(26), .CNT_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .cmd   (cmd_if),
    .stop  (stop),
    .a     (a),
    .b     (b),
    .dir   (dir),
    .busy  (busy),
    .done  (done),
    .pos   (pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        a;
    logic        b;
    logic [31:0] pos;
    int          cyc;
    logic        done;
  } exp_t;

  typedef struct {
    logic        do_reset;
    int          period;
    logic        dir;
    int          edges;
    logic        exp_a;
    logic        exp_b;
    logic [31:0] exp_pos;
  } vec_t;

  exp_t        exp_q[$];
  vec_t        vecs[3];
  int          checks;
  int          errors;
  int          cyc;
  int          stray_done;
  logic        prev_a;
  logic        prev_b;
  logic        last_acc;
  logic [1:0]  m_phase;
  logic [31:0] m_pos;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
               name, actual, expected, cyc);
    end
  endtask

  // One clock: note whether the command is taken, then sample at negedge
  // and score any channel change against the head of the queue.
  task automatic tick();
    exp_t e;
    #1 last_acc = cmd_if.cmd_valid && cmd_if.cmd_ready;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (reset && (a !== prev_a || b !== prev_b)) begin
      checkOutput("one_channel", 32'(int'(a ^ prev_a) + int'(b ^ prev_b)), 32'd1);
      checkOutput("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checkOutput("edge_ab", {30'd0, a, b}, {30'd0, e.a, e.b});
        checkOutput("edge_pos", pos, e.pos);
        checkOutput("edge_cycle", cyc, e.cyc);
        checkOutput("edge_done", {31'd0, done}, {31'd0, e.done});
      end
    end else if (done) begin
      stray_done++;
    end
    prev_a = a;
    prev_b = b;
  endtask

  // Reference phase/position model; queues the edges a command should make.
  task automatic model_push(input int n, input int per, input logic d,
                            input int t0, input logic done_last);
    exp_t e;
    int   per_eff;
    per_eff = (per < 2) ? 2 : per;
    for (int k = 1; k <= n; k++) begin
      m_phase = d ? m_phase + 2'd1 : m_phase - 2'd1;
      m_pos   = d ? m_pos + 32'd1  : m_pos - 32'd1;
      e.a    = m_phase[1] ^ m_phase[0];
      e.b    = m_phase[1];
      e.pos  = m_pos;
      e.cyc  = t0 + per_eff * k;
      e.done = done_last && (k == n);
      exp_q.push_back(e);
    end
  endtask

  task automatic applyStimulus(input int per, input logic d, input int edges,
                               output int acc_cyc);
    cmd_if.cmd_period = 26'(per);
    cmd_if.cmd_dir    = d;
    cmd_if.cmd_edges  = 16'(edges);
    cmd_if.cmd_valid  = 1'b1;
    acc_cyc = -1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (last_acc) begin
        acc_cyc = cyc;
        break;
      end
    end
    cmd_if.cmd_valid = 1'b0;
    checkOutput("accept_timeout", 32'(acc_cyc >= 0), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!busy) break;
      tick();
    end
    checkOutput("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    m_phase = 2'd0;
    m_pos   = 32'd0;
    exp_q.delete();
    tick();
    tick();
    prev_a = 1'b0;
    prev_b = 1'b0;
    reset = 1'b1;
    tick();
  endtask

  initial begin
    int t0;
    int t1;
    checks     = 0;
    errors     = 0;
    cyc        = 0;
    stray_done = 0;
    prev_a     = 1'b0;
    prev_b     = 1'b0;
    last_acc   = 1'b0;
    m_phase    = 2'd0;
    m_pos      = 32'd0;
    stop       = 1'b0;
    reset      = 1'b0;
    cmd_if.cmd_valid  = 1'b0;
    cmd_if.cmd_period = '0;
    cmd_if.cmd_dir    = 1'b0;
    cmd_if.cmd_edges  = '0;

    vecs[0] = '{1'b0, 10, 1'b1, 8, 1'b0, 1'b0, 32'd8};
    vecs[1] = '{1'b0, 4,  1'b0, 6, 1'b1, 1'b1, 32'd2};
    vecs[2] = '{1'b1, 0,  1'b0, 3, 1'b1, 1'b0, 32'hFFFF_FFFD};

    repeat (3) tick();
    checkOutput("rst_a", {31'd0, a}, 32'd0);
    checkOutput("rst_b", {31'd0, b}, 32'd0);
    checkOutput("rst_dir", {31'd0, dir}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_pos", pos, 32'd0);
    checkOutput("rst_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
    reset = 1'b1;
    tick();

    // Finite moves from idle.
    for (int i = 0; i < 3; i++) begin
      if (vecs[i].do_reset) do_reset();
      stray_done = 0;
      applyStimulus(vecs[i].period, vecs[i].dir, vecs[i].edges, t0);
      model_push(vecs[i].edges, vecs[i].period, vecs[i].dir, t0, 1'b1);
      tick();
      checkOutput("busy_running", {31'd0, busy}, 32'd1);
      wait_idle(vecs[i].edges * (vecs[i].period + 2) + 50);
      checkOutput("final_a", {31'd0, a}, {31'd0, vecs[i].exp_a});
      checkOutput("final_b", {31'd0, b}, {31'd0, vecs[i].exp_b});
      checkOutput("final_pos", pos, vecs[i].exp_pos);
      tick();
      checkOutput("done_one_cycle", {31'd0, done}, 32'd0);
      checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);
      checkOutput("stray_done", 32'(stray_done), 32'd0);
    end

    // Continuous move, then a buffered reverse command swapped in seamlessly.
    stray_done = 0;
    applyStimulus(20, 1'b1, 0, t0);
    model_push(2, 20, 1'b1, t0, 1'b0);
    while (cyc < t0 + 30) tick();
    applyStimulus(5, 1'b0, 4, t1);
    checkOutput("ready_low_pending", {31'd0, cmd_if.cmd_ready}, 32'd0);
    model_push(4, 5, 1'b0, t0 + 40, 1'b1);
    while (cyc < t0 + 40) tick();
    checkOutput("ready_after_swap", {31'd0, cmd_if.cmd_ready}, 32'd1);
    checkOutput("dir_after_swap", {31'd0, dir}, 32'd0);
    wait_idle(100);
    checkOutput("sb_drained_swap", 32'(exp_q.size()), 32'd0);
    checkOutput("stray_done_swap", 32'(stray_done), 32'd0);

    // Command accepted on the final edge of a finite move: no gap, no done.
    stray_done = 0;
    applyStimulus(6, 1'b1, 2, t0);
    model_push(2, 6, 1'b1, t0, 1'b0);
    while (cyc < t0 + 11) tick();
    applyStimulus(3, 1'b1, 2, t1);
    checkOutput("accept_on_final", 32'(t1), 32'(t0 + 12));
    checkOutput("busy_no_gap", {31'd0, busy}, 32'd1);
    model_push(2, 3, 1'b1, t0 + 12, 1'b1);
    wait_idle(50);
    checkOutput("sb_drained_final", 32'(exp_q.size()), 32'd0);
    checkOutput("stray_done_final", 32'(stray_done), 32'd0);

    // Stop mid-interval with a buffered command.
    stray_done = 0;
    applyStimulus(100, 1'b1, 0, t0);
    model_push(3, 100, 1'b1, t0, 1'b0);
    while (cyc < t0 + 350) tick();
    checkOutput("busy_before_stop", {31'd0, busy}, 32'd1);
    applyStimulus(7, 1'b0, 5, t1);
    checkOutput("ready_low_stop", {31'd0, cmd_if.cmd_ready}, 32'd0);
    stop = 1'b1;
    tick();
    checkOutput("busy_after_stop", {31'd0, busy}, 32'd0);
    checkOutput("done_after_stop", {31'd0, done}, 32'd0);
    stop = 1'b0;
    #1;
    checkOutput("ready_after_stop", {31'd0, cmd_if.cmd_ready}, 32'd1);
    checkOutput("pos_hold_stop", pos, m_pos);
    checkOutput("ab_hold_stop", {30'd0, a, b},
                {30'd0, m_phase[1] ^ m_phase[0], m_phase[1]});
    checkOutput("dir_hold_stop", {31'd0, dir}, 32'd1);
    repeat (60) tick();
    checkOutput("busy_stays_idle", {31'd0, busy}, 32'd0);
    checkOutput("sb_drained_stop", 32'(exp_q.size()), 32'd0);
    checkOutput("stray_done_stop", 32'(stray_done), 32'd0);

    // Asynchronous reset in the middle of an interval.
    applyStimulus(50, 1'b1, 0, t0);
    model_push(1, 50, 1'b1, t0, 1'b0);
    while (cyc < t0 + 70) tick();
    checkOutput("pos_before_reset", pos, m_pos);
    #2 reset = 1'b0;
    #1;
    checkOutput("arst_a", {31'd0, a}, 32'd0);
    checkOutput("arst_b", {31'd0, b}, 32'd0);
    checkOutput("arst_dir", {31'd0, dir}, 32'd0);
    checkOutput("arst_busy", {31'd0, busy}, 32'd0);
    checkOutput("arst_done", {31'd0, done}, 32'd0);
    checkOutput("arst_pos", pos, 32'd0);
    checkOutput("arst_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
    m_phase = 2'd0;
    m_pos   = 32'd0;
    exp_q.delete();
    prev_a  = 1'b0;
    prev_b  = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
